// File: rtl/sobol_int32_to_fp32.sv
// Converts a 32-bit unsigned Sobol word x into the FP32 bit pattern of x / 2^32.
// Three-stage elastic pipeline (S1 leading-one, S2 normalize, S3 pack/output).
module sobol_int32_to_fp32 #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [31:0]        in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [31:0]        out_data,
  input  logic               out_ready,
  output logic [COUNT_W-1:0] sample_cnt
);

  localparam int STAGES = 3;

  typedef struct packed {
    logic [31:0] x;
    logic [4:0]  p;
    logic        z;
  } s1_t;

  typedef struct packed {
    logic [22:0] frac;
    logic [4:0]  p;
    logic        z;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  logic [STAGES:1] en;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic [31:0]     s3_d;

  // A stage may load when it is empty or its successor takes its contents.
  always_comb begin
    en[3] = !vld_pipe[3] || out_ready;
    en[2] = !vld_pipe[2] || en[3];
    en[1] = !vld_pipe[1] || en[2];
  end

  assign in_ready  = en[1];
  assign out_valid = vld_pipe[3];

  // S1: leading-one position; highest set bit wins.
  always_comb begin
    s1_d   = '0;
    s1_d.x = in_data;
    s1_d.z = (in_data == 32'h0);
    for (int i = 0; i < 32; i++)
      if (in_data[i]) s1_d.p = 5'(i);
  end

  // S2: normalize so the hidden one sits at bit 31; keep the 23 bits below it.
  always_comb begin
    s2_d      = '0;
    s2_d.frac = 23'((s1_q.x << (5'd31 - s1_q.p)) >> 8);
    s2_d.p    = s1_q.p;
    s2_d.z    = s1_q.z;
  end

  // S3: exponent 127 - (32 - p); dropped LSBs truncate, so the result stays < 1.0.
  always_comb begin
    s3_d = '0;
    if (!s2_q.z)
      s3_d = {1'b0, 8'd95 + {3'b000, s2_q.p}, s2_q.frac};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      out_data   <= '0;
      sample_cnt <= '0;
    end else begin
      if (en[1]) vld_pipe[1] <= in_valid;
      if (en[2]) vld_pipe[2] <= vld_pipe[1];
      if (en[3]) vld_pipe[3] <= vld_pipe[2];
      if (en[1] && in_valid)    s1_q     <= s1_d;
      if (en[2] && vld_pipe[1]) s2_q     <= s2_d;
      if (en[3] && vld_pipe[2]) out_data <= s3_d;
      if (out_valid && out_ready) sample_cnt <= sample_cnt + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sobol_int32_to_fp32.sv
// Bench for sobol_int32_to_fp32: directed vectors, stall/reset sequences and a
// randomized handshake run scored against an independent conversion model.
module tb_sobol_int32_to_fp32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [15:0] sample_cnt;
  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [3:0]  s_cnt;

  always #5 clk = ~clk;

  sobol_int32_to_fp32 #(.COUNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .sample_cnt(sample_cnt));

  sobol_int32_to_fp32 #(.COUNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
    .out_ready(out_ready), .sample_cnt(s_cnt));

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  int drops = 0;
  bit mon_en = 1'b0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
  } vec_t;
  vec_t tbl[6];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // Reference: truncated x / 2^32 built from the msb position.
  function automatic logic [31:0] fp_ref(logic [31:0] x);
    int p;
    logic [22:0] man;
    if (x == 32'h0) return 32'h0;
    p = 31;
    while (!x[p]) p--;
    if (p >= 23) man = 23'(x >> (p - 23));
    else         man = 23'(x << (23 - p));
    return {1'b0, 8'(95 + p), man};
  endfunction

  function automatic logic [31:0] gen_word();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(7))
      0:       return 32'h0;
      1, 2:    return r >> $urandom_range(31);
      default: return r;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    n_out = 0;
    drops = 0;
  endtask

  // Scoreboard: sample at the falling edge, where inputs are settled.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(fp_ref(in_data));
      if (in_valid && !in_ready) drops++;
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("sb_extra_output", 32'd1, 32'd0);
        else check("sb_data", out_data, exp_q.pop_front());
      end
    end
  end

  // One word into an empty pipe: absent after 1 and 2 edges, present after 3.
  task automatic single_word(input logic [31:0] din, input logic [31:0] dout);
    in_valid = 1'b1;
    in_data = din;
    out_ready = 1'b1;
    check("sw_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("sw_lat1_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check("sw_lat2_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check("sw_lat3_valid", {31'b0, out_valid}, 32'd1);
    check("sw_lat3_data", out_data, dout);
    tick();
  endtask

  task automatic run_stream(input int n, input int vp, input int rp, output int cycles);
    int sent = 0;
    bit acc;
    logic [31:0] cur = gen_word();
    cycles = 0;
    mon_en = 1'b1;
    while (sent < n && cycles < n * 20 + 100) begin
      in_valid = ($urandom_range(99) < vp);
      in_data = cur;
      out_ready = ($urandom_range(99) < rp);
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      cycles++;
      if (acc) begin
        sent++;
        cur = gen_word();
      end
    end
    if (sent < n) check("stream_timeout", sent, n);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    check("stream_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    int cyc, k;
    bit acc, stable;
    logic [31:0] hold;

    tbl[0] = '{32'h8000_0000, 32'h3F00_0000};
    tbl[1] = '{32'h4000_0000, 32'h3E80_0000};
    tbl[2] = '{32'hFFFF_FFFF, 32'h3F7F_FFFF};
    tbl[3] = '{32'h0000_0001, 32'h2F80_0000};
    tbl[4] = '{32'h0000_0003, 32'h3040_0000};
    tbl[5] = '{32'h0000_0000, 32'h0000_0000};

    do_reset();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_sample_cnt", {16'b0, sample_cnt}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Directed conversions.
    for (int i = 0; i < 6; i++) single_word(tbl[i].din, tbl[i].dout);
    check("t1_sample_cnt", {16'b0, sample_cnt}, 32'd6);

    // Back-to-back, no stalls.
    do_reset();
    run_stream(100, 100, 100, cyc);
    check("t2_send_cycles", cyc, 32'd100);
    check("t2_in_ready_drops", drops, 32'd0);
    check("t2_outputs", n_out, 32'd100);
    check("t2_sample_cnt", {16'b0, sample_cnt}, 32'd100);

    // Stall with downstream blocked for 10 cycles.
    do_reset();
    mon_en = 1'b1;
    out_ready = 1'b0;
    k = 0;
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = 32'h1234_5678 >> k;
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) k++;
    end
    check("t3_accepts", k, 32'd3);
    check("t3_in_ready_low", {31'b0, in_ready}, 32'd0);
    check("t3_out_valid", {31'b0, out_valid}, 32'd1);
    hold = out_data;
    check("t3_head_data", hold, fp_ref(32'h1234_5678));
    for (int i = 0; i < 10; i++) begin
      in_data = 32'h1234_5678 >> k;
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) k++;
      if (out_data !== hold) stable = 1'b0;
    end
    check("t3_data_stable", {31'b0, stable}, 32'd1);
    check("t3_still_three", k, 32'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && k < 8; i++) begin
      in_valid = 1'b1;
      in_data = 32'h1234_5678 >> k;
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) k++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    check("t3_drained", exp_q.size(), 32'd0);
    check("t3_outputs", n_out, 32'd8);
    check("t3_sample_cnt", {16'b0, sample_cnt}, 32'd8);

    // Random handshakes, 10k words.
    do_reset();
    run_stream(10000, 70, 60, cyc);
    check("t4_outputs", n_out, 32'd10000);
    check("t4_sample_cnt", {16'b0, sample_cnt}, 32'd10000);

    // Reset with the pipe full; nothing may reappear afterwards.
    mon_en = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 32'hA000_0000 + i;
      tick();
    end
    in_valid = 1'b0;
    check("t5_full_in_ready", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_out_valid", {31'b0, out_valid}, 32'd0);
    check("t5_sample_cnt", {16'b0, sample_cnt}, 32'd0);
    check("t5_out_data", out_data, 32'h0);
    check("t5_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid !== 1'b0) stable = 1'b0;
    end
    check("t5_no_replay", {31'b0, stable}, 32'd1);
    single_word(32'h8000_0000, 32'h3F00_0000);

    // Counter wrap on the 4-bit instance.
    do_reset();
    run_stream(17, 100, 100, cyc);
    check("t6_cnt16", {16'b0, sample_cnt}, 32'd17);
    check("t6_cnt4_wrap", {28'b0, s_cnt}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
